pool_win_acc: RTL and testbench

3x3 window reduction stage directly downstream of the pooling row/column counter. It consumes the same pixel stream as the counter, plus the counter's window position (`r_cnt`/`c_cnt`) and window-done pulse. For each completed window it reduces the nine samples per lane to one pooled value. Results go out through a 2-entry output buffer with a valid/ready handshake towards the next layer.

---
 rtl/pool_pkg.sv | 12 +
 rtl/pool_out_fifo.sv | 55 +++++
 rtl/pool_win_acc.sv | 120 ++++++++++++
 tb/tb_pool_win_acc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared constants and types for the 3x3 pooling window stage
package pool_pkg;

    localparam int POOL_K    = 3;
    localparam int POOL_WIN  = POOL_K * POOL_K;
    localparam int AVG_RECIP = 7282;   // round(65536 / 9)
    localparam int AVG_SHIFT = 16;

    localparam int POOL_DATA_W = 8;
    typedef logic signed [POOL_DATA_W-1:0] pool_sample_t;

endpackage

// File: rtl/pool_out_fifo.sv
// rtl/pool_out_fifo.sv - 2-entry result buffer with valid/ready output
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and data; ignored when full unless popping
//   out_rdy             downstream accept
//   out_vld, out_data   head entry (out_data forced to 0 while empty)
//   full                both entries occupied
module pool_out_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    output logic         full
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         pop;
    logic         do_push;

    assign pop      = out_vld && out_rdy;
    // A pop frees the head slot on the same edge, so a full buffer still accepts.
    assign do_push  = push && (!full || pop);
    assign out_vld  = (count != 2'd0);
    assign full     = (count == 2'd2);
    assign out_data = out_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(pop);
        end
    end

endmodule

// File: rtl/pool_win_acc.sv
// rtl/pool_win_acc.sv - 3x3 window max/average reduction with 2-entry output buffer
//
// Optional feature macro: POOL_AVG_EN (average pooling; max-only when undefined).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_vld, in_data     sample stream, LANES lanes of signed DATA_W
//   r_cnt, c_cnt        window position of the current sample
//   win_done            pulse the cycle after the 9th sample of a window
//   avg_mode            1 = average, 0 = max (ignored without POOL_AVG_EN)
//   out_vld, out_data   pooled result, same lane packing as in_data
//   out_rdy             downstream accept
//   ovf                 sticky: a result was dropped on a full buffer
module pool_win_acc
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              r_cnt,
    input  logic [1:0]              c_cnt,
    input  logic                    win_done,
    input  logic                    avg_mode,
    output logic                    out_vld,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_rdy,
    output logic                    ovf
);

    localparam int SW = DATA_W + 4;        // holds 9 * min sample
    localparam int PW = SW + AVG_SHIFT;    // product width for the /9 multiply

    logic                    first;
    logic [LANES*DATA_W-1:0] push_data;
    logic                    full;
    logic                    drop;

    assign first = (r_cnt == 2'd0) && (c_cnt == 2'd0);

`ifndef POOL_AVG_EN
    logic unused_avg_mode;
    assign unused_avg_mode = avg_mode;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0] smp;
        logic signed [DATA_W-1:0] acc;
        logic signed [DATA_W-1:0] red;

        assign smp = $signed(in_data[k*DATA_W +: DATA_W]);

        // Pushes read the pre-edge value, so a load at (0,0) may share the
        // edge with the previous window's push.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (in_vld) begin
                if (first || (smp > acc)) begin
                    acc <= smp;
                end
            end
        end

`ifdef POOL_AVG_EN
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] smp_ext;
        logic signed [PW-1:0] prod;
        logic signed [DATA_W-1:0] avg;

        assign smp_ext = $signed({{(SW-DATA_W){smp[DATA_W-1]}}, smp});

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum <= '0;
            end else if (in_vld) begin
                sum <= first ? smp_ext : (sum + smp_ext);
            end
        end

        // /9 with round-half-up: multiply by 2^16/9, add half an LSB, shift.
        assign prod = $signed({{AVG_SHIFT{sum[SW-1]}}, sum}) * $signed(PW'(AVG_RECIP))
                    + $signed(PW'(32'd1 << (AVG_SHIFT - 1)));
        assign avg  = prod[AVG_SHIFT +: DATA_W];
        assign red  = avg_mode ? avg : acc;
`else
        assign red = acc;
`endif

        assign push_data[k*DATA_W +: DATA_W] = red;
    end

    // Full with no pop this cycle: the result is lost.
    assign drop = win_done && full && !out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    pool_out_fifo #(
        .W(LANES*DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (win_done && !drop),
        .push_data(push_data),
        .out_rdy  (out_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .full     (full)
    );

endmodule

// File: tb/tb_pool_win_acc.sv
// tb/tb_pool_win_acc.sv - self-checking bench for pool_win_acc
module tb_pool_win_acc;
    import pool_pkg::*;

    localparam int DW = 8;
    localparam int LN = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vld;
    logic [LN*DW-1:0] in_data;
    logic [1:0]       r_cnt;
    logic [1:0]       c_cnt;
    logic             win_done;
    logic             avg_mode;
    logic             out_vld;
    logic [LN*DW-1:0] out_data;
    logic             out_rdy;
    logic             ovf;

    always #5 clk = ~clk;

    pool_win_acc #(.DATA_W(DW), .LANES(LN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_data (in_data),
        .r_cnt   (r_cnt),
        .c_cnt   (c_cnt),
        .win_done(win_done),
        .avg_mode(avg_mode),
        .out_vld (out_vld),
        .out_data(out_data),
        .out_rdy (out_rdy),
        .ovf     (ovf)
    );

    typedef struct {
        bit avg;
        int s[9];
        int exp0;
    } vec_t;

    int               errors = 0;
    int               checks = 0;
    logic [LN*DW-1:0] sb_q[$];
    logic             exp_ovf = 1'b0;
    int               pos = 0;
    bit               pend = 1'b0;
    bit               pend_mode = 1'b0;
    logic [LN*DW-1:0] pend_val;
    logic [LN*DW-1:0] pend_lane0_only;
    int               win_s[LN][9];
    vec_t             vecs[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: max, or true /9 rounded half up.
    function automatic logic [LN*DW-1:0] reduce(bit avg);
        logic [LN*DW-1:0] r;
        for (int k = 0; k < LN; k++) begin
            int v;
            int sum;
            sum = 0;
            v = win_s[k][0];
            for (int i = 0; i < 9; i++) begin
                sum += win_s[k][i];
                if (win_s[k][i] > v) v = win_s[k][i];
            end
            if (avg) v = $rtoi($floor(real'(sum) / 9.0 + 0.5));
            r[k*DW +: DW] = DW'(v);
        end
        return r;
    endfunction

    task automatic monitor();
        check("out_vld", 32'(out_vld), 32'(sb_q.size() > 0));
        if (sb_q.size() > 0) check("out_data", out_data, sb_q[0]);
        check("ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    // One clock cycle: drive at negedge, check, advance the model, wait past posedge.
    task automatic step(bit vld, int lane0, bit mode);
        @(negedge clk);
        win_done = pend;
        avg_mode = pend ? pend_mode : mode;
        in_vld   = vld;
        r_cnt    = 2'(pos / 3);
        c_cnt    = 2'(pos % 3);
        if (vld) begin
            for (int k = 0; k < LN; k++) begin
                int s;
                s = (k == 0) ? lane0 : int'($urandom_range(0, 255)) - 128;
                in_data[k*DW +: DW] = DW'(s);
                win_s[k][pos] = s;
            end
        end else begin
            in_data = $urandom;
        end
        #1;
        monitor();
        if (sb_q.size() > 0 && out_rdy) void'(sb_q.pop_front());
        if (pend) begin
            if (sb_q.size() == 2) exp_ovf = 1'b1;
            else sb_q.push_back(pend_val);
        end
        pend = 1'b0;
        if (vld) begin
            if (pos == 8) begin
                pend      = 1'b1;
                pend_mode = mode;
                pend_val  = reduce(mode);
                pos       = 0;
            end else begin
                pos++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic window(int v, bit mode);
        for (int i = 0; i < 9; i++) step(1'b1, v, mode);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        vecs.push_back('{avg: 1'b0, s: '{-5, 3, -128, 127, 0, 1, 2, 3, 4}, exp0: 127});
        vecs.push_back('{avg: 1'b0, s: '{7, 7, 7, 7, 7, 7, 7, 7, 7}, exp0: 7});
        vecs.push_back('{avg: 1'b0, s: '{-3, -3, -3, -3, -3, -3, -3, -3, -3}, exp0: -3});
        vecs.push_back('{avg: 1'b0, s: '{-128, -128, -128, -128, -128, -128, -128, -128, -128}, exp0: -128});
`ifdef POOL_AVG_EN
        vecs.push_back('{avg: 1'b1, s: '{10, 10, 10, 10, 10, 10, 10, 10, 10}, exp0: 10});
        vecs.push_back('{avg: 1'b1, s: '{-127, -127, -127, -127, -127, -127, -127, -127, -127}, exp0: -127});
        vecs.push_back('{avg: 1'b1, s: '{1, 2, 3, 4, 5, 6, 7, 8, 9}, exp0: 5});
        vecs.push_back('{avg: 1'b0, s: '{-9, -8, -7, -6, -5, -4, -3, -2, -1}, exp0: -1});
`endif

        rst_n = 1'b0; in_vld = 1'b0; in_data = '0; r_cnt = '0; c_cnt = '0;
        win_done = 1'b0; avg_mode = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table windows back to back with in_vld continuous.
        for (int v = 0; v < vecs.size(); v++) begin
            for (int i = 0; i < 9; i++) step(1'b1, vecs[v].s[i], vecs[v].avg);
            check($sformatf("tbl%0d_lane0", v), 32'($signed(pend_val[DW-1:0])), 32'(vecs[v].exp0));
        end
        idle(4);

        // Partial window abandoned, counter restarts.
        for (int i = 0; i < 5; i++) step(1'b1, 100, 1'b0);
        idle(3);
        pos = 0;
        window(2, 1'b0);
        idle(4);

        // Backpressure over three windows: third result dropped.
        out_rdy = 1'b0;
        window(1, 1'b0);
        window(2, 1'b0);
        window(3, 1'b0);
        idle(3);
        check("ovf_set", 32'(ovf), 32'd1);
        check("held_head_lane0", 32'(out_data[DW-1:0]), 32'd1);
        out_rdy = 1'b1;
        idle(4);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Reset in the middle of a window.
        for (int i = 0; i < 4; i++) step(1'b1, 50, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_vld", 32'(out_vld), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        sb_q.delete();
        exp_ovf = 1'b0; pos = 0; pend = 1'b0;
        in_vld = 1'b0; win_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        window(9, 1'b0);
        idle(1);
        check("post_rst_lane0", 32'(out_data[DW-1:0]), 32'd9);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
